// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO write port among N requesters in bounded bursts.
// Define FIFO_WR_ARB_STATS_EN to add the beat_total / stall_cycles statistics outputs.
module fifo_wr_arbiter #(
  parameter int N         = 4,
  parameter int WIDTH     = 16,
  parameter int MAX_BURST = 4,
  localparam int OW       = (N > 1) ? $clog2(N) : 1,
  localparam int CW       = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1
) (
  input  logic               clk,
  input  logic               rst_,
  input  logic [N-1:0]       req,
  input  logic [N*WIDTH-1:0] wr_data,
  output logic [N-1:0]       gnt,
  input  logic               fifo_full,
  output logic               fifo_write,
  output logic [WIDTH-1:0]   fifo_data_in,
  output logic [OW-1:0]      owner,
  output logic               busy
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [31:0]        beat_total,
  output logic [31:0]        stall_cycles
`endif
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t           state;
  logic [CW-1:0]    beat_cnt;
  logic [OW-1:0]    next_owner;
  logic             found;
  logic             owner_req;
  logic [WIDTH-1:0] owner_data;
  logic             granting;
  logic             accept;
  logic             last_beat;

  // Rotating scan starting just after the previous owner gives round-robin fairness.
  always_comb begin
    int unsigned idx;
    next_owner = owner;
    found      = 1'b0;
    idx        = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = (32'(owner) + k) % N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        next_owner = OW'(idx);
      end
    end
  end

  always_comb begin
    owner_req  = 1'b0;
    owner_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (OW'(i) == owner) begin
        owner_req  = req[i];
        owner_data = wr_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Reset is synchronous but must still suppress a write in the cycle it is sampled.
  assign granting  = (state == BURST) && !fifo_full && !rst_;
  assign accept    = granting && owner_req;
  assign last_beat = (beat_cnt == CW'(MAX_BURST - 1));

  always_comb begin
    gnt = '0;
    if (granting) gnt[owner] = 1'b1;
  end

  assign fifo_write   = accept;
  assign fifo_data_in = accept ? owner_data : '0;
  assign busy         = (state == BURST);

  always_ff @(posedge clk) begin
    if (rst_) begin
      state    <= IDLE;
      owner    <= OW'(N - 1);
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found && !fifo_full) begin
            owner    <= next_owner;
            beat_cnt <= '0;
            state    <= BURST;
          end
        end
        BURST: begin
          if (!fifo_full) begin
            if (owner_req) begin
              if (last_beat) begin
                state    <= IDLE;
                beat_cnt <= '0;
              end else begin
                beat_cnt <= beat_cnt + CW'(1);
              end
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst_) begin
      beat_total   <= '0;
      stall_cycles <= '0;
    end else begin
      if (accept && (beat_total != '1)) beat_total <= beat_total + 32'd1;
      if ((state == BURST) && fifo_full && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule
